// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decode/issue stage feeding the 16-bit shifter.
// Takes a 16-bit instruction plus its rt operand over valid/ready, filters
// illegal encodings, and issues {hyrja, shamt, funct, rd} from a registered
// head slot backed by one skid register so back-pressure never loses work.
// The head slot is a one-entry output register and the skid slot is behind it,
// which gives two entries in total.
module shift_issue_stage #(
    parameter logic [3:0] OPC_SHIFT = 4'b0000,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic [15:0]      in_rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_hyrja,
    output logic [3:0]       out_shamt,
    output logic [1:0]       out_funct,
    output logic [1:0]       out_rd,
    output logic             illegal_err,
    input  logic             illegal_clr,
    output logic [CNT_W-1:0] issue_count
);

    // Legal iff the opcode selects a shift and funct is SLL (00) or SRL (01).
    function automatic logic is_legal(input logic [3:0] opc, input logic [1:0] fn);
        logic ok;
        ok = 1'b0;
        if (opc == OPC_SHIFT) begin
            ok = (fn == 2'b00) || (fn == 2'b01);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Instruction fields; rs is carried in the encoding but has no consumer here.
    logic [3:0]  opc_s;
    logic [1:0]  rd_s;
    logic [3:0]  shamt_s;
    logic [1:0]  funct_s;
    logic [1:0]  rs_unused_s;
    logic [1:0]  rt_unused_s;

    assign opc_s       = in_instr[15:12];
    assign rs_unused_s = in_instr[11:10];
    assign rt_unused_s = in_instr[9:8];
    assign rd_s        = in_instr[7:6];
    assign shamt_s     = in_instr[5:2];
    assign funct_s     = in_instr[1:0];

    // Head (output) register.
    logic             head_valid_r;
    logic [15:0]      head_hyrja_r;
    logic [3:0]       head_shamt_r;
    logic [1:0]       head_funct_r;
    logic [1:0]       head_rd_r;

    // Skid register.
    logic             skid_valid_r;
    logic [15:0]      skid_hyrja_r;
    logic [3:0]       skid_shamt_r;
    logic [1:0]       skid_funct_r;
    logic [1:0]       skid_rd_r;

    logic             illegal_err_r;
    logic [CNT_W-1:0] issue_count_r;

    // Handshake and routing decisions.
    logic accept_s;
    logic legal_s;
    logic push_s;
    logic pop_s;
    logic head_free_s;

    // Derive handshake events and whether the head slot can take new data this edge.
    always_comb begin
        accept_s    = 1'b0;
        legal_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        head_free_s = 1'b0;
        accept_s    = in_valid && !skid_valid_r;
        legal_s     = is_legal(opc_s, funct_s);
        if (accept_s) begin
            push_s = legal_s;
        end else begin
            push_s = 1'b0;
        end
        pop_s       = head_valid_r && out_ready;
        head_free_s = !head_valid_r || pop_s;
    end

    // Head/skid buffer: skid drains to head first, else new packet loads head,
    // else a stalled head pushes the new packet into skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_r <= 1'b0;
            head_hyrja_r <= 16'h0000;
            head_shamt_r <= 4'h0;
            head_funct_r <= 2'b00;
            head_rd_r    <= 2'b00;
            skid_valid_r <= 1'b0;
            skid_hyrja_r <= 16'h0000;
            skid_shamt_r <= 4'h0;
            skid_funct_r <= 2'b00;
            skid_rd_r    <= 2'b00;
        end else if (head_free_s) begin
            if (skid_valid_r) begin
                head_valid_r <= 1'b1;
                head_hyrja_r <= skid_hyrja_r;
                head_shamt_r <= skid_shamt_r;
                head_funct_r <= skid_funct_r;
                head_rd_r    <= skid_rd_r;
                skid_valid_r <= 1'b0;
            end else if (push_s) begin
                head_valid_r <= 1'b1;
                head_hyrja_r <= in_rt_data;
                head_shamt_r <= shamt_s;
                head_funct_r <= funct_s;
                head_rd_r    <= rd_s;
            end else begin
                head_valid_r <= 1'b0;
            end
        end else begin
            if (push_s) begin
                skid_valid_r <= 1'b1;
                skid_hyrja_r <= in_rt_data;
                skid_shamt_r <= shamt_s;
                skid_funct_r <= funct_s;
                skid_rd_r    <= rd_s;
            end else begin
                skid_valid_r <= skid_valid_r;
            end
        end
    end

    // Sticky illegal flag: a new illegal accept wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_err_r <= 1'b0;
        end else if (accept_s && !legal_s) begin
            illegal_err_r <= 1'b1;
        end else if (illegal_clr) begin
            illegal_err_r <= 1'b0;
        end else begin
            illegal_err_r <= illegal_err_r;
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            issue_count_r <= issue_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            issue_count_r <= issue_count_r;
        end
    end

    // in_ready comes straight from the skid occupancy flop.
    assign in_ready    = !skid_valid_r;
    assign out_valid   = head_valid_r;
    assign out_hyrja   = head_hyrja_r;
    assign out_shamt   = head_shamt_r;
    assign out_funct   = head_funct_r;
    assign out_rd      = head_rd_r;
    assign illegal_err = illegal_err_r;
    assign issue_count = issue_count_r;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage. A second instance with
// CNT_W=2 shares every input so the counter wrap can be observed alongside.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_hyrja;
    logic [3:0]  out_shamt;
    logic [1:0]  out_funct;
    logic [1:0]  out_rd;
    logic        illegal_err;
    logic        illegal_clr;
    logic [7:0]  issue_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] out_hyrja2;
    logic [3:0]  out_shamt2;
    logic [1:0]  out_funct2;
    logic [1:0]  out_rd2;
    logic        illegal_err2;
    logic [1:0]  issue_count2;

    int n_cmp;
    int n_err;

    shift_issue_stage #(.OPC_SHIFT(4'b0000), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rt_data(in_rt_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_hyrja(out_hyrja), .out_shamt(out_shamt),
        .out_funct(out_funct), .out_rd(out_rd), .illegal_err(illegal_err),
        .illegal_clr(illegal_clr), .issue_count(issue_count)
    );

    shift_issue_stage #(.OPC_SHIFT(4'b0000), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_rt_data(in_rt_data), .out_valid(out_valid2),
        .out_ready(out_ready), .out_hyrja(out_hyrja2), .out_shamt(out_shamt2),
        .out_funct(out_funct2), .out_rd(out_rd2), .illegal_err(illegal_err2),
        .illegal_clr(illegal_clr), .issue_count(issue_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mk(input logic [3:0] opc, input logic [1:0] rd,
                                       input logic [3:0] sh, input logic [1:0] fn);
        return {opc, 2'b00, 2'b00, rd, sh, fn};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; in_rt_data = 16'h0000;
        out_ready = 1'b0; illegal_clr = 1'b0;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if ({out_hyrja, out_shamt, out_funct, out_rd} !== 24'h000000) begin n_err++; $display("FAIL reset_fields got %h want 000000", {out_hyrja, out_shamt, out_funct, out_rd}); end
        n_cmp++; if (illegal_err !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal_err); end
        n_cmp++; if (issue_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", issue_count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h0049; in_rt_data = 16'h0400;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if ({out_hyrja, out_shamt, out_funct, out_rd} !== {16'h0400, 4'd2, 2'b01, 2'd1}) begin n_err++;
            $display("FAIL single_fields got %h/%h/%b/%h want 0400/2/01/1", out_hyrja, out_shamt, out_funct, out_rd); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drop got %b want 0", out_valid); end
        n_cmp++; if (issue_count !== 8'd1) begin n_err++; $display("FAIL single_count got %0d want 1", issue_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(4'h0, 2'd2, 4'd3, 2'b00); in_rt_data = 16'hA5A5;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a got %b want 1", in_ready); end
        in_instr = mk(4'h0, 2'd3, 4'd7, 2'b01); in_rt_data = 16'h1234;
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_b got %b want 0", in_ready); end
        in_instr = mk(4'h0, 2'd0, 4'd9, 2'b00); in_rt_data = 16'hCCCC;
        step();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", in_ready); end
        n_cmp++; if ({out_valid, out_hyrja, out_shamt, out_funct, out_rd} !== {1'b1, 16'hA5A5, 4'd3, 2'b00, 2'd2}) begin n_err++;
            $display("FAIL bp_head_a got %b/%h/%h/%b/%h want 1/a5a5/3/00/2", out_valid, out_hyrja, out_shamt, out_funct, out_rd); end
        out_ready = 1'b1;
        step();
        n_cmp++; if ({out_valid, out_hyrja, out_shamt, out_funct, out_rd} !== {1'b1, 16'h1234, 4'd7, 2'b01, 2'd3}) begin n_err++;
            $display("FAIL bp_head_b got %b/%h/%h/%b/%h want 1/1234/7/01/3", out_valid, out_hyrja, out_shamt, out_funct, out_rd); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_drain got %b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", out_valid); end
        n_cmp++; if (issue_count !== 8'd3) begin n_err++; $display("FAIL bp_count got %0d want 3", issue_count); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk(4'h3, 2'd1, 4'd1, 2'b00); in_rt_data = 16'hDEAD;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready1 got %b want 1", in_ready); end
        n_cmp++; if (illegal_err !== 1'b1) begin n_err++; $display("FAIL ill_err_opc got %b want 1", illegal_err); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ill_valid1 got %b want 0", out_valid); end
        in_instr = mk(4'h0, 2'd1, 4'd1, 2'b10);
        step();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready2 got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ill_valid2 got %b want 0", out_valid); end
        illegal_clr = 1'b1;
        step();
        n_cmp++; if (illegal_err !== 1'b0) begin n_err++; $display("FAIL ill_clr got %b want 0", illegal_err); end
        in_valid = 1'b1; in_instr = mk(4'h0, 2'd0, 4'd0, 2'b11);
        step();
        in_valid = 1'b0; illegal_clr = 1'b0;
        n_cmp++; if (illegal_err !== 1'b1) begin n_err++; $display("FAIL ill_set_prio got %b want 1", illegal_err); end
        n_cmp++; if (issue_count !== 8'd3) begin n_err++; $display("FAIL ill_count got %0d want 3", issue_count); end
        illegal_clr = 1'b1;
        step();
        illegal_clr = 1'b0;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_instr = mk(4'h0, 2'(i), 4'(i), 2'(i % 2));
            in_rt_data = 16'h0100 + 16'(i);
            step();
            n_cmp++;
            if ({out_valid, out_hyrja, out_shamt} !== {1'b1, 16'h0100 + 16'(i), 4'(i)}) begin n_err++;
                $display("FAIL stream_%0d got %b/%h/%h want 1/%h/%h", i, out_valid, out_hyrja, out_shamt, 16'h0100 + 16'(i), 4'(i)); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_end got %b want 0", out_valid); end
        n_cmp++; if (issue_count !== 8'd13) begin n_err++; $display("FAIL stream_count got %0d want 13", issue_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(4'h0, 2'd1, 4'd15, 2'b00); in_rt_data = 16'h1111;
        step();
        in_rt_data = 16'h2222;
        step();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full got %b want 0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL mid_rst_flags got %b want 01", {out_valid, in_ready}); end
        n_cmp++; if (issue_count !== 8'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", issue_count); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_instr = mk(4'h0, 2'd2, 4'd0, 2'b01); in_rt_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_hyrja, out_shamt, out_funct, out_rd} !== {1'b1, 16'hBEEF, 4'd0, 2'b01, 2'd2}) begin n_err++;
            $display("FAIL mid_after got %b/%h/%h/%b/%h want 1/beef/0/01/2", out_valid, out_hyrja, out_shamt, out_funct, out_rd); end
        step();
        n_cmp++; if (issue_count !== 8'd1) begin n_err++; $display("FAIL mid_count got %0d want 1", issue_count); end
    endtask

    task automatic test_counter_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = mk(4'h0, 2'd0, 4'(i), 2'b00); in_rt_data = 16'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (issue_count !== 8'd5) begin n_err++; $display("FAIL wrap_count8 got %0d want 5", issue_count); end
        n_cmp++; if (issue_count2 !== 2'd1) begin n_err++; $display("FAIL wrap_count2 got %0d want 1", issue_count2); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_illegal();
        test_streaming();
        test_reset_mid();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
